// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-dispatch instruction FIFO, first-word-fall-through with flush
module instr_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_pc_next,
    input  logic [31:0]              enq_instr,
    output logic                     full,
    input  logic                     deq,
    output logic                     deq_valid,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_pc_next,
    output logic [31:0]              deq_instr,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [95:0]    mem_q [DEPTH];
    logic [95:0]    head;
    logic           push, pop;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        count     = wr_ptr_q - rd_ptr_q;
        deq_valid = !empty;
    end

    always_comb begin
        push     = enq && !full && !flush;
        pop      = deq && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {enq_pc, enq_pc_next, enq_instr};
        end
    end

    always_comb begin
        head        = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
        deq_pc      = head[95:64];
        deq_pc_next = head[63:32];
        deq_instr   = head[31:0];
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
    a_full_empty:  assert property (@(posedge clk) disable iff (rst) !(full && empty));
    a_valid:       assert property (@(posedge clk) disable iff (rst) deq_valid == !empty);
endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard bench for instr_queue
module tb_instr_queue;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, enq = 1'b0, deq = 1'b0;
    logic [31:0] enq_pc = '0, enq_pc_next = '0, enq_instr = '0;
    logic        full, deq_valid, empty;
    logic [31:0] deq_pc, deq_pc_next, deq_instr;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_fail = 0;
    int mcnt = 0;
    logic [95:0] exp_q[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq(enq), .enq_pc(enq_pc), .enq_pc_next(enq_pc_next), .enq_instr(enq_instr),
        .full(full), .deq(deq), .deq_valid(deq_valid),
        .deq_pc(deq_pc), .deq_pc_next(deq_pc_next), .deq_instr(deq_instr),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mcnt));
        chk({tag, ".empty"}, 32'(empty), 32'(mcnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(mcnt == DEPTH));
        chk({tag, ".deq_valid"}, 32'(deq_valid), 32'(mcnt != 0));
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic step(input string tag, input logic f, input logic e, input logic d,
                        input logic [31:0] pc);
        logic push, pop;
        flush = f; enq = e; deq = d;
        enq_pc = pc; enq_pc_next = pc + 32'd4; enq_instr = instr_of(pc);
        push = e && !f && (mcnt < DEPTH);
        pop  = d && !f && (mcnt > 0);
        if (push) exp_q.push_back({pc, pc + 32'd4, instr_of(pc)});
        @(posedge clk); #1;
        if (f) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            mcnt = mcnt + int'(push) - int'(pop);
        end
        flush = 1'b0; enq = 1'b0; deq = 1'b0;
        chk_status(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mcnt = 0;
        chk_status("reset");
        chk("reset.deq_pc", deq_pc, 32'h0);
        chk("reset.deq_instr", deq_instr, 32'h0);
    endtask

    // Monitor: consumes expected entries on every accepted pop.
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (deq && deq_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mon.unexpected_pop", 32'(deq_valid), 32'h0);
                end else begin
                    chk("mon.deq_pc", deq_pc, exp_q[0][95:64]);
                    chk("mon.deq_pc_next", deq_pc_next, exp_q[0][63:32]);
                    chk("mon.deq_instr", deq_instr, exp_q[0][31:0]);
                    void'(exp_q.pop_front());
                end
            end else if (!deq_valid) begin
                chk("mon.idle_pc", deq_pc, 32'h0);
                chk("mon.idle_instr", deq_instr, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        do_reset();

        // 1: fill to full, 17th push ignored
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, 32'h1eceb000 + 32'(4 * i));
        step("fill17", 1'b0, 1'b1, 1'b0, 32'hdead0000);

        // 2: drain in order, extra deq ignored
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, 1'b1, 32'h0);
        step("drain_extra", 1'b0, 1'b0, 1'b1, 32'h0);

        // 3: single push latency
        step("lat_push", 1'b0, 1'b1, 1'b0, 32'h0000_4000);
        chk("lat.deq_instr", deq_instr, instr_of(32'h0000_4000));
        step("lat_pop", 1'b0, 1'b0, 1'b1, 32'h0);

        // 4: steady occupancy of 8 with simultaneous push/pop
        pc = 32'h2000_0000;
        for (int i = 0; i < 8; i++) begin
            step("ss_fill", 1'b0, 1'b1, 1'b0, pc);
            pc += 32'd4;
        end
        for (int i = 0; i < 40; i++) begin
            step("ss_pp", 1'b0, 1'b1, 1'b1, pc);
            pc += 32'd4;
        end
        for (int i = 0; i < 8; i++) step("ss_drain", 1'b0, 1'b0, 1'b1, 32'h0);

        // 5: flush beats enq and deq in the same cycle
        for (int i = 0; i < 5; i++) step("fl_fill", 1'b0, 1'b1, 1'b0, 32'h3000_0000 + 32'(4 * i));
        step("flush", 1'b1, 1'b1, 1'b1, 32'hbad0_0000);
        step("flush_empty", 1'b1, 1'b0, 1'b0, 32'h0);
        step("post_fl_push", 1'b0, 1'b1, 1'b0, 32'h3100_0000);
        step("post_fl_pop", 1'b0, 1'b0, 1'b1, 32'h0);

        // 6: full queue, enq+deq -> only the pop happens
        for (int i = 0; i < DEPTH; i++) step("f6_fill", 1'b0, 1'b1, 1'b0, 32'h4000_0000 + 32'(4 * i));
        step("f6_pp", 1'b0, 1'b1, 1'b1, 32'hbad1_0000);
        chk("f6.count", 32'(count), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) step("f6_drain", 1'b0, 1'b0, 1'b1, 32'h0);

        // reset mid-operation discards contents
        for (int i = 0; i < 3; i++) step("rs_fill", 1'b0, 1'b1, 1'b0, 32'h5000_0000 + 32'(4 * i));
        do_reset();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
